// File: rtl/count_seq_checker_pkg.sv
// count_chk_pkg
//   Shared definitions for the counter-sequence checker: FSM state type and
//   the width of the debug state output.
package count_chk_pkg;

  localparam int STATE_W = 2;

  // Encoding is visible on the debug state output, so values are fixed.
  typedef enum logic [STATE_W-1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_t;

endpackage

// File: rtl/count_seq_checker_if.sv
// count_seq_checker_if
//   Bundles the sample/control inputs and status outputs of the counter
//   sequence checker.
//   master: drives en, q_in, clr_err; observes status.
//   slave : the checker; consumes samples, drives locked, mismatch,
//           err_count, expected, state.
interface count_seq_checker_if
  import count_chk_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int ERR_W = 8
) ();

  logic               en;
  logic [WIDTH-1:0]   q_in;
  logic               clr_err;
  logic               locked;
  logic               mismatch;
  logic [ERR_W-1:0]   err_count;
  logic [WIDTH-1:0]   expected;
  logic [STATE_W-1:0] state;

  modport master (
    output en, q_in, clr_err,
    input  locked, mismatch, err_count, expected, state
  );

  modport slave (
    input  en, q_in, clr_err,
    output locked, mismatch, err_count, expected, state
  );

endinterface

// File: rtl/count_seq_checker_sat_counter.sv
// sat_counter
//   W-bit up-counter that sticks at all-ones. clr has priority over inc.
//   Ports: clk, rst (async, active-high), inc, clr, count[W-1:0].
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != {W{1'b1}})) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/count_seq_checker.sv
// count_seq_checker
//   Monitors a free-running up-counter value. Locks after LOCK_COUNT
//   consecutive +1 steps, then pulses mismatch on any sample that breaks the
//   sequence and counts such events in a saturating counter.
//   Ports: clk, rst (async, active-high), bus (count_seq_checker_if.slave):
//     en/q_in sample strobe and value, clr_err synchronous error clear,
//     locked, mismatch, err_count, expected, state status outputs.
module count_seq_checker
  import count_chk_pkg::*;
#(
  parameter int WIDTH      = 4,
  parameter int LOCK_COUNT = 4,
  parameter int ERR_W      = 8
) (
  input logic                clk,
  input logic                rst,
  count_seq_checker_if.slave bus
);

  localparam int RUN_W = $clog2(LOCK_COUNT + 1);

  state_t             state_q,    state_d;
  logic [RUN_W-1:0]   run_q,      run_d;
  logic [WIDTH-1:0]   expected_q, expected_d;
  logic               mismatch_q, mismatch_d;
  logic [RUN_W-1:0]   run_inc;
  logic               hit;
  logic [ERR_W-1:0]   err_count;

  assign hit     = (bus.q_in == expected_q);
  assign run_inc = run_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    run_d      = run_q;
    expected_d = expected_q;
    mismatch_d = 1'b0;

    // Every accepted sample re-arms the prediction; wrap to 0 is intended.
    if (bus.en) begin
      expected_d = bus.q_in + 1'b1;
    end

    case (state_q)
      HUNT: begin
        if (bus.en) begin
          run_d   = '0;
          state_d = VERIFY;
        end
      end
      VERIFY: begin
        if (bus.en) begin
          if (hit) begin
            run_d = run_inc;
            if (run_inc == RUN_W'(LOCK_COUNT)) begin
              state_d = LOCKED;
            end
          end else begin
            // Out-of-sequence while not yet locked: just resync silently.
            run_d = '0;
          end
        end
      end
      LOCKED: begin
        if (bus.en && !hit) begin
          mismatch_d = 1'b1;
          run_d      = '0;
          state_d    = VERIFY;
        end
      end
      default: begin
        // Unused encoding recovers to HUNT without needing a sample.
        run_d   = '0;
        state_d = HUNT;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= HUNT;
      run_q      <= '0;
      expected_q <= '0;
      mismatch_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      run_q      <= run_d;
      expected_q <= expected_d;
      mismatch_q <= mismatch_d;
    end
  end

  // Driven from mismatch_d so the count moves on the same edge the pulse appears.
  sat_counter #(
    .W (ERR_W)
  ) u_err_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (mismatch_d),
    .clr   (bus.clr_err),
    .count (err_count)
  );

  assign bus.locked    = (state_q == LOCKED);
  assign bus.mismatch  = mismatch_q;
  assign bus.err_count = err_count;
  assign bus.expected  = expected_q;
  assign bus.state     = state_q;

endmodule

// File: tb/tb_count_seq_checker.sv
module tb_count_seq_checker;

  localparam int LOCK = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  count_seq_checker_if #(.WIDTH(4), .ERR_W(8)) bus8 ();
  count_seq_checker_if #(.WIDTH(4), .ERR_W(2)) bus2 ();

  count_seq_checker #(.WIDTH(4), .LOCK_COUNT(LOCK), .ERR_W(8)) u8 (
    .clk (clk), .rst (rst), .bus (bus8.slave)
  );
  count_seq_checker #(.WIDTH(4), .LOCK_COUNT(LOCK), .ERR_W(2)) u2 (
    .clk (clk), .rst (rst), .bus (bus2.slave)
  );

  int pass_cnt = 0;
  int total    = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Behavioural model: lock status follows from the length of the trailing
  // streak of correct +1 steps among accepted samples.
  bit has_prev = 0;
  int last     = 0;
  int streak   = 0;
  bit m_mm     = 0;
  int m_err8   = 0;
  int m_err2   = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      has_prev = 0; last = 0; streak = 0; m_mm = 0; m_err8 = 0; m_err2 = 0;
    end else begin
      m_mm = 0;
      if (bus8.en) begin
        if (has_prev) begin
          if (int'(bus8.q_in) == (last + 1) % 16) streak++;
          else begin
            if (streak >= LOCK) m_mm = 1;
            streak = 0;
          end
        end else streak = 0;
        has_prev = 1;
        last = int'(bus8.q_in);
      end
      if (bus8.clr_err) begin
        m_err8 = 0; m_err2 = 0;
      end else if (m_mm) begin
        if (m_err8 < 255) m_err8++;
        if (m_err2 < 3) m_err2++;
      end
    end
  end

  function automatic int m_state();
    if (!has_prev) return 0;
    return (streak >= LOCK) ? 2 : 1;
  endfunction

  function automatic int m_expected();
    return has_prev ? (last + 1) % 16 : 0;
  endfunction

  always @(negedge clk) begin
    check("u8.state",    int'(bus8.state),     m_state());
    check("u8.locked",   int'(bus8.locked),    int'(m_state() == 2));
    check("u8.mismatch", int'(bus8.mismatch),  int'(m_mm));
    check("u8.err",      int'(bus8.err_count), m_err8);
    check("u8.expected", int'(bus8.expected),  m_expected());
    check("u2.state",    int'(bus2.state),     m_state());
    check("u2.locked",   int'(bus2.locked),    int'(m_state() == 2));
    check("u2.mismatch", int'(bus2.mismatch),  int'(m_mm));
    check("u2.err",      int'(bus2.err_count), m_err2);
    check("u2.expected", int'(bus2.expected),  m_expected());
  end

  // Apply one sample to both checkers; returns at the following negedge.
  task automatic step(input logic e, input logic [3:0] q, input logic c);
    bus8.en = e; bus8.q_in = q; bus8.clr_err = c;
    bus2.en = e; bus2.q_in = q; bus2.clr_err = c;
    @(negedge clk);
  endtask

  logic [3:0] lv;
  logic [3:0] qv;

  initial begin
    step(1'b0, 4'd0, 1'b0);
    @(negedge clk);
    check("reset.state", int'(bus8.state), 0);
    check("reset.err",   int'(bus8.err_count), 0);
    rst = 1'b0;

    // Acquire lock on 0,1,2,3,4,5
    step(1'b1, 4'd0, 1'b0);
    check("t1.verify", int'(bus8.state), 1);
    check("t1.exp1", int'(bus8.expected), 1);
    for (int v = 1; v <= 3; v++) step(1'b1, 4'(v), 1'b0);
    check("t1.notyet", int'(bus8.locked), 0);
    step(1'b1, 4'd4, 1'b0);
    check("t1.locked", int'(bus8.locked), 1);
    step(1'b1, 4'd5, 1'b0);

    // Wrap F->0 while locked
    for (int v = 6; v <= 17; v++) step(1'b1, 4'(v % 16), 1'b0);
    check("t2.wrap_locked", int'(bus8.locked), 1);

    // Break sequence with 9 after 7
    for (int v = 2; v <= 7; v++) step(1'b1, 4'(v), 1'b0);
    step(1'b1, 4'd9, 1'b0);
    check("t3.mismatch", int'(bus8.mismatch), 1);
    check("t3.err", int'(bus8.err_count), 1);
    check("t3.locked", int'(bus8.locked), 0);
    check("t3.exp", int'(bus8.expected), 10);
    step(1'b1, 4'd10, 1'b0);
    check("t3.pulse_end", int'(bus8.mismatch), 0);
    for (int v = 11; v <= 13; v++) step(1'b1, 4'(v), 1'b0);
    check("t3.relock", int'(bus8.locked), 1);

    // Disabled samples ignored
    for (int v = 14; v <= 19; v++) step(1'b1, 4'(v % 16), 1'b0);
    step(1'b0, 4'd8, 1'b0);
    step(1'b0, 4'd8, 1'b0);
    check("t4.hold_exp", int'(bus8.expected), 4);
    step(1'b1, 4'd4, 1'b0);
    check("t4.no_mm", int'(bus8.mismatch), 0);
    check("t4.locked", int'(bus8.locked), 1);
    check("t4.exp", int'(bus8.expected), 5);

    // Saturation on the ERR_W=2 instance; clear coincident with 6th mismatch
    lv = 4'd4;
    for (int k = 1; k <= 6; k++) begin
      qv = lv + 4'd3;
      step(1'b1, qv, (k == 6));
      check("t5.mm_pulse", int'(bus2.mismatch), 1);
      if (k == 5) begin
        check("t5.sat2", int'(bus2.err_count), 3);
        check("t5.cnt8", int'(bus8.err_count), 6);
      end
      if (k == 6) begin
        check("t5.clr2", int'(bus2.err_count), 0);
        check("t5.clr8", int'(bus8.err_count), 0);
      end
      for (int j = 1; j <= 4; j++) step(1'b1, qv + 4'(j), 1'b0);
      lv = qv + 4'd4;
    end

    // One more error so the reset below has history to discard
    qv = lv + 4'd5;
    step(1'b1, qv, 1'b0);
    for (int j = 1; j <= 4; j++) step(1'b1, qv + 4'(j), 1'b0);
    check("t6.pre_locked", int'(bus8.locked), 1);
    check("t6.pre_err", int'(bus8.err_count), 1);

    // Asynchronous reset between edges
    #2 rst = 1'b1;
    #1;
    check("t6.locked", int'(bus8.locked), 0);
    check("t6.err", int'(bus8.err_count), 0);
    check("t6.exp", int'(bus8.expected), 0);
    check("t6.state", int'(bus8.state), 0);
    @(negedge clk);
    rst = 1'b0;

    // Randomized mostly-in-sequence traffic
    lv = 4'd0;
    for (int i = 0; i < 3000; i++) begin
      logic e, c;
      e = ($urandom_range(0, 9) < 8);
      c = ($urandom_range(0, 31) == 0);
      if ($urandom_range(0, 19) == 0) qv = 4'($urandom_range(0, 15));
      else qv = lv + 4'd1;
      step(e, qv, c);
      if (e) lv = qv;
    end

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
